// File: rtl/secded_pkg.sv
// secded_pkg - shared types and elaboration-time helpers for the SECDED codec.
//   mode_e   : transaction direction (ENC = 0, DEC = 1)
//   calc_p   : number of Hamming parity bits P for a given data width
//   is_pow2  : true when a codeword position index is a power of two
package secded_pkg;

  typedef enum logic {ENC = 1'b0, DEC = 1'b1} mode_e;

  // Smallest p with 2^p >= dw + p + 1 (scan downwards so the last hit is the smallest).
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    for (int k = 30; k >= 1; k--) begin
      if ((1 << k) >= dw + k + 1) p = k;
    end
    return p;
  endfunction

  function automatic logic is_pow2(input int idx);
    return (idx > 0) && ((idx & (idx - 1)) == 0);
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// secded_syndrome - combinational Hamming syndrome and overall parity.
//   word   in  N  codeword (or placed data with zeroed parity slots)
//   syn    out P  XOR of the indices of all set bits in positions 1..N-1
//   parity out 1  XOR of all N bits
module secded_syndrome #(
  parameter int N = 16,
  parameter int P = 4
) (
  input  logic [N-1:0] word,
  output logic [P-1:0] syn,
  output logic         parity
);

  always_comb begin
    syn = '0;
    for (int i = 1; i < N; i++) begin
      if (word[i]) syn = syn ^ P'(i);
    end
  end

  assign parity = ^word;

endmodule

// File: rtl/secded_codec.sv
// secded_codec - two-stage pipelined SECDED encoder/decoder with valid/ready.
//   Clk, Reset_n        clock, synchronous active-low reset
//   InValid/InReady     input handshake; InMode 0=encode 1=decode; InData N bits
//   OutValid/OutReady   output handshake; OutMode, OutData, OutSingle,
//                       OutDouble, OutSyndrome describe the presented result
//   CntClr, CntSingle, CntDouble  saturating decode error counters
// Build option: define SECDED_CNT_EN to build the error counters; otherwise
// the counter outputs are tied to 0 and CntClr is ignored.
module secded_codec
  import secded_pkg::*;
#(
  parameter  int DW    = 11,
  parameter  int CNT_W = 8,
  localparam int P     = calc_p(DW),
  localparam int N     = DW + P + 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic             InMode,
  input  logic [N-1:0]     InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             OutMode,
  output logic [N-1:0]     OutData,
  output logic             OutSingle,
  output logic             OutDouble,
  output logic [P-1:0]     OutSyndrome,
  input  logic             CntClr,
  output logic [CNT_W-1:0] CntSingle,
  output logic [CNT_W-1:0] CntDouble
);

  localparam int NPOS = 1 << P;
  // Bit s set when syndrome s names a real codeword position.
  localparam logic [NPOS-1:0] IN_RANGE = {NPOS{1'b1}} >> (NPOS - N);

  function automatic logic [N-1:0] place(input logic [DW-1:0] d);
    logic [N-1:0] w;
    int j;
    w = '0;
    j = 0;
    for (int i = 3; i < N; i++) begin
      if (!is_pow2(i)) begin
        w[i] = d[j];
        j++;
      end
    end
    return w;
  endfunction

  function automatic logic [DW-1:0] extract(input logic [N-1:0] w);
    logic [DW-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 3; i < N; i++) begin
      if (!is_pow2(i)) begin
        d[j] = w[i];
        j++;
      end
    end
    return d;
  endfunction

  logic         adv;
  mode_e        in_mode;
  logic [N-1:0] in_word;
  logic [P-1:0] in_syn;
  logic         in_par;

  logic         s1_valid;
  mode_e        s1_mode;
  logic [N-1:0] s1_word;
  logic [P-1:0] s1_syn;
  logic         s1_par;

  logic         out_valid;
  mode_e        out_mode;
  logic [N-1:0] out_data;
  logic         out_single;
  logic         out_double;
  logic [P-1:0] out_syn;

  logic [N-1:0] cw;
  logic [N-1:0] fixed;
  logic         s_oob;
  logic         nxt_single;
  logic         nxt_double;
  logic [N-1:0] nxt_data;
  logic [P-1:0] nxt_syn;

  assign adv     = ~out_valid | OutReady;
  assign InReady = adv;

  // Encode runs the placed data (parity slots still 0) through the same
  // syndrome unit; the resulting syndrome bits are exactly the parity bits.
  assign in_mode = mode_e'(InMode);
  assign in_word = (in_mode == DEC) ? InData : place(InData[DW-1:0]);

  secded_syndrome #(.N(N), .P(P)) u_syndrome (
    .word   (in_word),
    .syn    (in_syn),
    .parity (in_par)
  );

  always_comb begin
    cw = s1_word;
    for (int k = 0; k < P; k++) cw[1 << k] = s1_syn[k];
    cw[0] = ^cw[N-1:1];

    s_oob      = ~IN_RANGE[s1_syn];
    nxt_single = s1_par & ~s_oob;
    nxt_double = (~s1_par & (s1_syn != '0)) | (s1_par & s_oob);

    fixed = s1_word;
    for (int i = 0; i < N; i++) begin
      if (nxt_single && (s1_syn == P'(i))) fixed[i] = ~fixed[i];
    end

    nxt_data = '0;
    nxt_syn  = '0;
    if (s1_mode == ENC) begin
      nxt_data   = cw;
      nxt_single = 1'b0;
      nxt_double = 1'b0;
    end else begin
      nxt_data[DW-1:0] = extract(fixed);
      nxt_syn          = s1_syn;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid   <= 1'b0;
      s1_mode    <= ENC;
      s1_word    <= '0;
      s1_syn     <= '0;
      s1_par     <= 1'b0;
      out_valid  <= 1'b0;
      out_mode   <= ENC;
      out_data   <= '0;
      out_single <= 1'b0;
      out_double <= 1'b0;
      out_syn    <= '0;
    end else if (adv) begin
      s1_valid   <= InValid;
      s1_mode    <= in_mode;
      s1_word    <= in_word;
      s1_syn     <= in_syn;
      s1_par     <= in_par;
      out_valid  <= s1_valid;
      out_mode   <= s1_mode;
      out_data   <= nxt_data;
      out_single <= nxt_single;
      out_double <= nxt_double;
      out_syn    <= nxt_syn;
    end
  end

  assign OutValid    = out_valid;
  assign OutMode     = out_mode;
  assign OutData     = out_data;
  assign OutSingle   = out_single;
  assign OutDouble   = out_double;
  assign OutSyndrome = out_syn;

`ifdef SECDED_CNT_EN
  logic             hs_dec;
  logic [CNT_W-1:0] cnt_single;
  logic [CNT_W-1:0] cnt_double;

  assign hs_dec = out_valid & OutReady & (out_mode == DEC);

  always_ff @(posedge Clk) begin
    if (!Reset_n || CntClr) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else begin
      if (hs_dec && out_single && (cnt_single != '1)) cnt_single <= cnt_single + CNT_W'(1);
      if (hs_dec && out_double && (cnt_double != '1)) cnt_double <= cnt_double + CNT_W'(1);
    end
  end

  assign CntSingle = cnt_single;
  assign CntDouble = cnt_double;
`else
  logic cnt_clr_unused;
  assign cnt_clr_unused = CntClr;
  assign CntSingle      = '0;
  assign CntDouble      = '0;
`endif

endmodule

// File: tb/tb_secded_codec.sv
module tb_secded_codec;

  localparam int DW    = 11;
  localparam int N     = 16;
  localparam int P     = 4;
  localparam int CNT_W = 2;

  logic             Clk;
  logic             Reset_n;
  logic             InValid;
  logic             InReady;
  logic             InMode;
  logic [N-1:0]     InData;
  logic             OutValid;
  logic             OutReady;
  logic             OutMode;
  logic [N-1:0]     OutData;
  logic             OutSingle;
  logic             OutDouble;
  logic [P-1:0]     OutSyndrome;
  logic             CntClr;
  logic [CNT_W-1:0] CntSingle;
  logic [CNT_W-1:0] CntDouble;

  secded_codec #(.DW(DW), .CNT_W(CNT_W)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .InValid     (InValid),
    .InReady     (InReady),
    .InMode      (InMode),
    .InData      (InData),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .OutMode     (OutMode),
    .OutData     (OutData),
    .OutSingle   (OutSingle),
    .OutDouble   (OutDouble),
    .OutSyndrome (OutSyndrome),
    .CntClr      (CntClr),
    .CntSingle   (CntSingle),
    .CntDouble   (CntDouble)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        mode;
    logic [15:0] din;
    logic [15:0] dout;
    logic        sgl;
    logic        dbl;
    logic [3:0]  syn;
  } vec_t;

  typedef struct {
    logic        mode;
    logic [15:0] data;
    logic        sgl;
    logic        dbl;
    logic [3:0]  syn;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;
  logic sb_on = 1'b0;
  logic rand_rdy = 1'b0;
  logic rdy_force = 1'b1;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model straight from the layout rules.
  function automatic logic is_data_pos(input int pos);
    return (pos >= 3) && ((pos & (pos - 1)) != 0);
  endfunction

  function automatic logic [15:0] m_enc(input logic [10:0] d);
    logic [15:0] cw;
    int j;
    cw = '0;
    j = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if (is_data_pos(pos)) begin
        cw[pos] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      logic p;
      p = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if (is_data_pos(pos) && (((pos >> k) & 1) == 1)) p = p ^ cw[pos];
      cw[1 << k] = p;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [10:0] m_ext(input logic [15:0] w);
    logic [10:0] d;
    int j;
    d = '0;
    j = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if (is_data_pos(pos)) begin
        d[j] = w[pos];
        j++;
      end
    end
    return d;
  endfunction

  // Decode by search: a valid codeword is clean, one bit away is a single
  // error at that bit, anything else is a double error.
  function automatic exp_t m_model(input logic mode, input logic [15:0] w);
    exp_t e;
    logic [15:0] w2;
    logic [3:0]  s;
    e.mode = mode;
    e.sgl  = 1'b0;
    e.dbl  = 1'b0;
    e.syn  = '0;
    if (mode == 1'b0) begin
      e.data = m_enc(w[10:0]);
      return e;
    end
    e.data = {5'b0, m_ext(w)};
    if (m_enc(m_ext(w)) == w) return e;
    for (int b = 0; b < 16; b++) begin
      w2 = w ^ (16'h1 << b);
      if (m_enc(m_ext(w2)) == w2) begin
        e.sgl  = 1'b1;
        e.syn  = 4'(b);
        e.data = {5'b0, m_ext(w2)};
        return e;
      end
    end
    s = '0;
    for (int pos = 1; pos < 16; pos++) if (w[pos]) s = s ^ 4'(pos);
    e.dbl = 1'b1;
    e.syn = s;
    return e;
  endfunction

  // OutReady driver; updates 2 time units after each rising edge.
  initial begin
    OutReady = 1'b1;
    forever begin
      @(posedge Clk);
      #2;
      OutReady = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Scoreboard: handshakes are judged at the falling edge, completing on the next rise.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Reset_n) exp_q.delete();
      else if (sb_on) begin
        if (OutValid && OutReady) begin
          if (exp_q.size() == 0) chk("sb_extra_output", 32'(OutValid), 32'(0));
          else begin
            e = exp_q.pop_front();
            chk("sb_mode", 32'(OutMode), 32'(e.mode));
            chk("sb_data", 32'(OutData), 32'(e.data));
            chk("sb_single", 32'(OutSingle), 32'(e.sgl));
            chk("sb_double", 32'(OutDouble), 32'(e.dbl));
            chk("sb_syndrome", 32'(OutSyndrome), 32'(e.syn));
          end
          n_out++;
        end
        if (InValid && InReady) exp_q.push_back(m_model(InMode, InData));
      end
    end
  end

  task automatic sync();
    @(posedge Clk);
    #1;
  endtask

  // Call between a rising edge and the following falling edge.
  task automatic send(input logic m, input logic [15:0] d);
    int waited;
    waited  = 0;
    InValid = 1'b1;
    InMode  = m;
    InData  = d;
    @(negedge Clk);
    while (!InReady && waited < 50) begin
      @(negedge Clk);
      waited++;
    end
    if (!InReady) chk("send_timeout", 32'(InReady), 32'(1));
    @(posedge Clk);
    #1;
    InValid = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 60) begin
      @(negedge Clk);
      c++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    sync();
    send(v.mode, v.din);
    @(negedge Clk);
    chk({tag, "_latency_early"}, 32'(OutValid), 32'(0));
    @(negedge Clk);
    chk({tag, "_valid"}, 32'(OutValid), 32'(1));
    chk({tag, "_mode"}, 32'(OutMode), 32'(v.mode));
    chk({tag, "_data"}, 32'(OutData), 32'(v.dout));
    chk({tag, "_single"}, 32'(OutSingle), 32'(v.sgl));
    chk({tag, "_double"}, 32'(OutDouble), 32'(v.dbl));
    chk({tag, "_syndrome"}, 32'(OutSyndrome), 32'(v.syn));
  endtask

  initial begin
    vec_t        vecs[6];
    logic [15:0] bp[4];
    logic [15:0] cw;
    int          c;

    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0};
    vecs[1] = '{1'b0, 16'h0001, 16'h000F, 1'b0, 1'b0, 4'd0};
    vecs[2] = '{1'b1, 16'h002F, 16'h0001, 1'b1, 1'b0, 4'd5};
    vecs[3] = '{1'b1, 16'h000E, 16'h0001, 1'b1, 1'b0, 4'd0};
    vecs[4] = '{1'b1, 16'h000C, 16'h0001, 1'b0, 1'b1, 4'd1};
    vecs[5] = '{1'b1, 16'h000F, 16'h0001, 1'b0, 1'b0, 4'd0};

    Reset_n = 1'b0;
    InValid = 1'b0;
    InMode  = 1'b0;
    InData  = '0;
    CntClr  = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_out_valid", 32'(OutValid), 32'(0));
    chk("rst_in_ready", 32'(InReady), 32'(1));
    chk("rst_out_data", 32'(OutData), 32'(0));
    chk("rst_flags", 32'({OutSingle, OutDouble, OutMode}), 32'(0));
    chk("rst_syndrome", 32'(OutSyndrome), 32'(0));
    chk("rst_cnt", 32'({CntSingle, CntDouble}), 32'(0));

    // Directed vectors
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: two words fill the pipe, a third waits, output held 3 cycles
    bp[0] = 16'h0123; bp[1] = 16'h0456; bp[2] = 16'h07FF; bp[3] = 16'h0001;
    rdy_force = 1'b0;
    sync();
    sync();
    n_out = 0;
    sb_on = 1'b1;
    send(1'b0, bp[0]);
    send(1'b0, bp[1]);
    InValid = 1'b1;
    InMode  = 1'b0;
    InData  = bp[2];
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("bp_out_valid", 32'(OutValid), 32'(1));
      chk("bp_in_ready", 32'(InReady), 32'(0));
      chk("bp_out_hold", 32'(OutData), 32'(m_enc(bp[0][10:0])));
    end
    rdy_force = 1'b1;
    send(1'b0, bp[2]);
    send(1'b0, bp[3]);
    drain();
    repeat (3) @(negedge Clk);
    chk("bp_count", 32'(n_out), 32'(4));

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    sync();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) sync();
      if ($urandom_range(0, 1) == 0) begin
        send(1'b0, 16'($urandom));
      end else begin
        int b1;
        int b2;
        cw = m_enc(11'($urandom));
        b1 = int'($urandom_range(0, 15));
        b2 = (b1 + int'($urandom_range(1, 15))) % 16;
        case ($urandom_range(0, 2))
          1: cw = cw ^ (16'h1 << b1);
          2: cw = cw ^ (16'h1 << b1) ^ (16'h1 << b2);
          default: ;
        endcase
        send(1'b1, cw);
      end
    end
    rand_rdy  = 1'b0;
    rdy_force = 1'b1;
    drain();

`ifdef SECDED_CNT_EN
    sync();
    CntClr = 1'b1;
    sync();
    CntClr = 1'b0;
    @(negedge Clk);
    chk("cnt_clear", 32'({CntSingle, CntDouble}), 32'(0));
    sync();
    for (int i = 0; i < 5; i++) send(1'b1, m_enc(11'(i + 3)) ^ (16'h1 << (i + 1)));
    drain();
    repeat (2) @(negedge Clk);
    chk("cnt_single_sat", 32'(CntSingle), 32'(3));
    chk("cnt_double_idle", 32'(CntDouble), 32'(0));
    sync();
    send(1'b1, 16'h000C);
    drain();
    repeat (2) @(negedge Clk);
    chk("cnt_double_one", 32'(CntDouble), 32'(1));
    sync();
    send(1'b1, 16'h000C);
    c = 0;
    while (!OutValid && c < 20) begin
      @(negedge Clk);
      c++;
    end
    chk("cnt_dbl_valid", 32'(OutValid), 32'(1));
    CntClr = 1'b1;
    @(posedge Clk);
    #1 CntClr = 1'b0;
    @(negedge Clk);
    chk("cnt_clr_wins", 32'(CntDouble), 32'(0));
    chk("cnt_clr_single", 32'(CntSingle), 32'(0));
    sync();
    send(1'b1, 16'h002F);
    drain();
    repeat (2) @(negedge Clk);
`else
    repeat (2) @(negedge Clk);
    chk("cnt_tied_single", 32'(CntSingle), 32'(0));
    chk("cnt_tied_double", 32'(CntDouble), 32'(0));
`endif

    // Reset with both stages full
    sb_on     = 1'b0;
    rdy_force = 1'b0;
    sync();
    sync();
    send(1'b0, 16'h0123);
    send(1'b0, 16'h0456);
    @(negedge Clk);
    chk("full_before_rst", 32'(OutValid), 32'(1));
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    sync();
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst2_out_valid", 32'(OutValid), 32'(0));
    chk("rst2_in_ready", 32'(InReady), 32'(1));
    chk("rst2_out_data", 32'(OutData), 32'(0));
    chk("rst2_cnt", 32'({CntSingle, CntDouble}), 32'(0));
    @(negedge Clk);
    chk("rst2_no_ghost", 32'(OutValid), 32'(0));
    rdy_force = 1'b1;
    sync();
    run_vec(vecs[1], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/secded_codec.md
# secded_codec

Parametrised, pipelined SECDED (extended Hamming) encoder/decoder for arbitrary data width. Works in either direction, selected per transaction: it encodes DW data bits into an N-bit codeword, or decodes an N-bit codeword, correcting single errors and flagging double errors. It sits between the register file/data memory path and the ALU as a streaming unit with valid/ready handshakes. It also keeps optional saturating error counters for diagnostics.

## Interface
- DW, 11, data bits per word (≥ 4)
- P, derived, smallest integer with 2^P ≥ DW+P+1 (DW=11 → P=4)
- N, derived, DW+P+1 codeword bits (DW=11 → N=16)
- CNT_W, 8, error-counter width
- Clk  in  1  clock, all state on rising edge
- Reset_n  in  1  reset, synchronous, active-low
- InValid  in  1  input word valid
- InReady  out  1  block can accept input this cycle
- InMode  in  1  0 = encode, 1 = decode
- InData  in  N  encode: data in [DW-1:0], upper bits ignored; decode: codeword
- OutValid  out  1  result valid
- OutReady  in  1  downstream accepts result
- OutMode  out  1  mode of the presented result
- OutData  out  N  encode: codeword; decode: corrected data in [DW-1:0], upper bits 0
- OutSingle  out  1  decode: single error detected and corrected
- OutDouble  out  1  decode: uncorrectable double error
- OutSyndrome  out  P  decode: Hamming syndrome; 0 on encode
- CntClr  in  1  clear both error counters
- CntSingle  out  CNT_W  saturating count of single errors (macro-gated)
- CntDouble  out  CNT_W  saturating count of double errors (macro-gated)

## Operation
- Codeword layout: bit 0 holds overall parity p0. Bits 1..N-1 are Hamming positions. Position 2^k holds parity bit p(2^k). Data bits fill the remaining positions in ascending order, so data[0] sits at position 3.
- Encode: p(2^k) = XOR of all data positions whose index has bit k set. p0 = XOR of bits 1..N-1, giving even overall parity.
- Decode: s = XOR of the indices of all set bits in positions 1..N-1, P bits wide. q = XOR of all N bits.
  - q=0, s=0: clean. Both flags 0.
  - q=1: single error at position s; s=0 means p0 itself flipped. Flip that bit, then extract data. OutSingle=1.
  - q=0, s≠0: double error. Data is extracted uncorrected. OutDouble=1.
- Syndrome position s ≥ N cannot arise from a single error in a valid layout; treat it as a double error.
- Counters count only on the output handshake (OutValid & OutReady) of a decode result with the matching flag set.
  - Counters saturate at 2^CNT_W−1.
  - If CntClr and an increment happen in the same cycle, clear wins: the result is 0.

## Timing
- Two register stages:
  - S1 registers the input word, mode, s and q.
  - S2 registers the corrected/extracted data or codeword, plus flags.
- Latency is 2 cycles from input handshake to OutValid when there is no backpressure. Throughput is 1 word/cycle.
- Pipeline advance enable: adv = ~OutValid | OutReady. InReady = adv, combinational from OutReady and OutValid.
- When adv=0, both stages hold. OutData, flags and OutValid stay stable until the handshake.
- A bubble (S1 empty) propagates as OutValid=0. A stage's valid bit loads only on adv.
- Reset (Reset_n=0 at a clock edge), including mid-transfer: all valid bits go to 0 and in-flight words are dropped. OutData, OutSyndrome and the flags go to 0. OutMode goes to 0. Counters go to 0. InReady=1 in the first cycle after reset.

## Configuration
- SECDED_CNT_EN defined: CntSingle/CntDouble counters and CntClr logic are present.
- SECDED_CNT_EN undefined: counters are not built, CntSingle/CntDouble are tied to 0, CntClr is ignored, and datapath behaviour is unchanged.

## Structure
- Package secded_pkg holds:
  - A function computing P from DW.
  - A function returning whether a position index is a power of two.
  - A typedef enum for mode: ENC=0, DEC=1.
- Sub-module secded_syndrome: combinational. Input is an N-bit word; outputs are s (P bits) and q. Encode uses it on the placed-data word, with parity slots 0, to obtain the parity bits. Decode uses it on the received codeword.
- Top level holds data placement/extraction, correction, the two pipeline stages, the handshake and the counters.

## Test plan
- Encode InData=11'h000 → OutData=16'h0000. Encode 11'h001 → OutData=16'h000F. Both with flags 0 and latency 2.
- Decode 16'h000F^16'h0020 → OutData=11'h001, OutSingle=1, OutSyndrome=5. Decode 16'h000E → OutData=11'h001, OutSingle=1, OutSyndrome=0.
- Decode 16'h000F^16'h0003 → OutDouble=1, OutSingle=0, OutSyndrome=1. Decode 16'h000F → both flags 0.
- Backpressure: stream 4 encodes back-to-back and hold OutReady=0 for 3 cycles.
  - OutData stays stable and InReady=0 while OutValid=1.
  - All 4 results emerge in order, none lost or duplicated.
- Counters, with SECDED_CNT_EN and CNT_W=2: 5 single-error decodes → CntSingle=3 (saturated). Assert CntClr on the cycle of a further double-error handshake → CntDouble=0.
- Assert Reset_n=0 with both stages full: next cycle OutValid=0, counters 0, InReady=1. Encode 11'h001 afterwards → 16'h000F.
